// File: rtl/pipe_collision_detect.sv
// Per-frame collision check of the bird box against the in-scope pipe, the floor and the ceiling.
// It filters transient pipe hits and holds Stop to the scroller until Ack.
module pipe_collision_detect #(
    parameter int unsigned BIRD_X_L = 300,
    parameter int unsigned BIRD_X_R = 320,
    parameter int unsigned BIRD_H   = 16,
    parameter int unsigned FLOOR_Y  = 480,
    parameter int unsigned CONFIRM  = 2
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_frame_tick,
    input  logic       i_q_count,
    input  logic [9:0] i_x_l,
    input  logic [9:0] i_x_r,
    input  logic [9:0] i_gap_top,
    input  logic [9:0] i_gap_bot,
    input  logic [9:0] i_bird_y,
    input  logic       i_ack,
    output logic       o_stop,
    output logic [1:0] o_hit_kind,
    output logic [9:0] o_crash_x,
    output logic       o_q_idle,
    output logic       o_q_armed,
    output logic       o_q_stop
);

    localparam logic [9:0]  L_BIRD_X_L = 10'(BIRD_X_L);
    localparam logic [9:0]  L_BIRD_X_R = 10'(BIRD_X_R);
    localparam logic [10:0] L_BIRD_H   = 11'(BIRD_H);
    localparam logic [10:0] L_FLOOR_Y  = 11'(FLOOR_Y);
    localparam logic [3:0]  L_CONFIRM  = 4'(CONFIRM);

    typedef enum logic [2:0] {
        StIdle  = 3'b001,
        StArmed = 3'b010,
        StStop  = 3'b100
    } state_e;

    state_e     r_state;
    logic       r_stop;
    logic [1:0] r_hit_kind;
    logic [9:0] r_crash_x;
    logic [2:0] r_hit_cnt;

    logic [9:0]  w_eff_l;
    logic [10:0] w_bird_bot;
    logic        w_h_ovl;
    logic        w_pipe;
    logic        w_floor;
    logic        w_ceil;
    logic [1:0]  w_kind;
    logic [3:0]  w_cnt_inc;
    logic        w_confirm;

    always_comb begin
        // A left edge past the right edge means it wrapped off the left of the screen.
        w_eff_l    = (i_x_l > i_x_r) ? 10'd0 : i_x_l;
        w_h_ovl    = (w_eff_l < L_BIRD_X_R) && (i_x_r > L_BIRD_X_L);
        w_bird_bot = {1'b0, i_bird_y} + L_BIRD_H;
        w_pipe     = w_h_ovl && ((i_bird_y < i_gap_top) || (w_bird_bot > {1'b0, i_gap_bot}));
        w_floor    = (w_bird_bot >= L_FLOOR_Y);
        w_ceil     = (i_bird_y == 10'd0);
        if (w_floor)     w_kind = 2'b10;
        else if (w_ceil) w_kind = 2'b11;
        else if (w_pipe) w_kind = 2'b01;
        else             w_kind = 2'b00;
        w_cnt_inc  = {1'b0, r_hit_cnt} + 4'd1;
        w_confirm  = w_floor || w_ceil || (w_pipe && (w_cnt_inc == L_CONFIRM));
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= StIdle;
            r_stop     <= 1'b0;
            r_hit_kind <= 2'b00;
            r_crash_x  <= 10'd0;
            r_hit_cnt  <= 3'd0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (i_q_count) begin
                        r_state    <= StArmed;
                        r_hit_cnt  <= 3'd0;
                        r_hit_kind <= 2'b00;
                        r_crash_x  <= 10'd0;
                    end
                end
                StArmed: begin
                    // Scroller leaving Count wins over a coincident tick.
                    if (!i_q_count) begin
                        r_state <= StIdle;
                    end else if (i_frame_tick) begin
                        if (w_confirm) begin
                            r_state    <= StStop;
                            r_stop     <= 1'b1;
                            r_hit_kind <= w_kind;
                            r_crash_x  <= i_x_l;
                        end else if (w_pipe) begin
                            if (w_cnt_inc <= L_CONFIRM) r_hit_cnt <= w_cnt_inc[2:0];
                        end else begin
                            r_hit_cnt <= 3'd0;
                        end
                    end
                end
                StStop: begin
                    if (i_ack) begin
                        r_state <= StIdle;
                        r_stop  <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_stop     = r_stop;
    assign o_hit_kind = r_hit_kind;
    assign o_crash_x  = r_crash_x;
    assign o_q_idle   = (r_state == StIdle);
    assign o_q_armed  = (r_state == StArmed);
    assign o_q_stop   = (r_state == StStop);

endmodule

// File: tb/tb_pipe_collision_detect.sv
// Directed bench for pipe_collision_detect: confirm filtering, floor/ceiling priority,
// wrap handling, frozen outputs in Stop, Ack release and asynchronous reset.
module tb_pipe_collision_detect;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_tick;
    logic       q_count;
    logic [9:0] x_l, x_r, gap_top, gap_bot, bird_y;
    logic       ack;
    logic       stop;
    logic [1:0] hit_kind;
    logic [9:0] crash_x;
    logic       q_idle, q_armed, q_stop;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_collision_detect dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_frame_tick (frame_tick),
        .i_q_count    (q_count),
        .i_x_l        (x_l),
        .i_x_r        (x_r),
        .i_gap_top    (gap_top),
        .i_gap_bot    (gap_bot),
        .i_bird_y     (bird_y),
        .i_ack        (ack),
        .o_stop       (stop),
        .o_hit_kind   (hit_kind),
        .o_crash_x    (crash_x),
        .o_q_idle     (q_idle),
        .o_q_armed    (q_armed),
        .o_q_stop     (q_stop)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic set_scene(input logic [9:0] xl, input logic [9:0] xr, input logic [9:0] by);
        x_l     = xl;
        x_r     = xr;
        gap_top = 10'd200;
        gap_bot = 10'd300;
        bird_y  = by;
    endtask

    task automatic arm();
        q_count = 1'b1;
        step();
    endtask

    task automatic release_stop();
        ack = 1'b1;
        step();
        ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; frame_tick = 1'b0; q_count = 1'b0; ack = 1'b0;
        set_scene(10'd0, 10'd0, 10'd100);
        step(); step();
        checks++;
        if ({q_idle, q_armed, q_stop, stop, hit_kind, crash_x} !== {3'b100, 1'b0, 2'b00, 10'd0}) begin
            errors++;
            $display("FAIL reset: state=%b stop=%b kind=%b crash=%0d, required state=100 stop=0 kind=00 crash=0",
                     {q_idle, q_armed, q_stop}, stop, hit_kind, crash_x);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_pipe_confirm();
        set_scene(10'd290, 10'd370, 10'd100);
        arm();
        checks++;
        if (q_armed !== 1'b1) begin
            errors++; $display("FAIL arm: q_armed=%b required 1", q_armed);
        end
        tick();
        checks++;
        if (stop !== 1'b0 || q_armed !== 1'b1) begin
            errors++; $display("FAIL pipe_tick1: stop=%b armed=%b required stop=0 armed=1", stop, q_armed);
        end
        tick();
        checks++;
        if ({stop, q_stop, hit_kind, crash_x} !== {1'b1, 1'b1, 2'b01, 10'd290}) begin
            errors++;
            $display("FAIL pipe_tick2: stop=%b q_stop=%b kind=%b crash=%0d, required 1 1 01 290",
                     stop, q_stop, hit_kind, crash_x);
        end
        release_stop();
    endtask

    task automatic test_hit_restart();
        set_scene(10'd290, 10'd370, 10'd100);
        arm();
        tick();
        bird_y = 10'd220;
        tick();
        bird_y = 10'd100;
        tick();
        checks++;
        if (stop !== 1'b0 || q_armed !== 1'b1) begin
            errors++; $display("FAIL restart_no_stop: stop=%b armed=%b required stop=0 armed=1", stop, q_armed);
        end
        x_l = 10'd295;
        tick();
        checks++;
        if ({stop, hit_kind, crash_x} !== {1'b1, 2'b01, 10'd295}) begin
            errors++;
            $display("FAIL restart_confirm: stop=%b kind=%b crash=%0d required 1 01 295", stop, hit_kind, crash_x);
        end
        release_stop();
    endtask

    task automatic test_floor_ceil();
        set_scene(10'd100, 10'd150, 10'd470);
        arm();
        tick();
        checks++;
        if ({stop, hit_kind, crash_x} !== {1'b1, 2'b10, 10'd100}) begin
            errors++;
            $display("FAIL floor: stop=%b kind=%b crash=%0d required 1 10 100", stop, hit_kind, crash_x);
        end
        release_stop();
        // Re-arm clears latched results.
        q_count = 1'b0;
        set_scene(10'd500, 10'd560, 10'd0);
        arm();
        checks++;
        if (hit_kind !== 2'b00 || crash_x !== 10'd0) begin
            errors++; $display("FAIL rearm_clear: kind=%b crash=%0d required 00 0", hit_kind, crash_x);
        end
        tick();
        checks++;
        if ({stop, hit_kind, crash_x} !== {1'b1, 2'b11, 10'd500}) begin
            errors++;
            $display("FAIL ceil: stop=%b kind=%b crash=%0d required 1 11 500", stop, hit_kind, crash_x);
        end
        release_stop();
        // Bird in pipe column and on floor: floor wins.
        set_scene(10'd290, 10'd370, 10'd464);
        arm();
        tick();
        checks++;
        if ({stop, hit_kind} !== {1'b1, 2'b10}) begin
            errors++; $display("FAIL floor_prio: stop=%b kind=%b required 1 10", stop, hit_kind);
        end
        release_stop();
        // One row above the floor line with no pipe: no hit.
        set_scene(10'd500, 10'd560, 10'd463);
        arm();
        tick(); tick();
        checks++;
        if (stop !== 1'b0) begin
            errors++; $display("FAIL floor_edge: stop=%b required 0", stop);
        end
        q_count = 1'b0;
        step();
    endtask

    task automatic test_wrap();
        set_scene(10'd640, 10'd40, 10'd100);
        arm();
        tick(); tick(); tick();
        checks++;
        if (stop !== 1'b0 || q_armed !== 1'b1) begin
            errors++; $display("FAIL wrap_no_ovl: stop=%b armed=%b required 0 1", stop, q_armed);
        end
        x_r = 10'd310;
        tick(); tick();
        checks++;
        if ({stop, hit_kind, crash_x} !== {1'b1, 2'b01, 10'd640}) begin
            errors++;
            $display("FAIL wrap_hit: stop=%b kind=%b crash=%0d required 1 01 640", stop, hit_kind, crash_x);
        end
    endtask

    task automatic test_stop_hold();
        // Entered with Stop held from test_wrap.
        set_scene(10'd100, 10'd200, 10'd470);
        q_count = 1'b0;
        tick(); tick(); step();
        checks++;
        if ({q_stop, stop, hit_kind, crash_x} !== {1'b1, 1'b1, 2'b01, 10'd640}) begin
            errors++;
            $display("FAIL stop_frozen: q_stop=%b stop=%b kind=%b crash=%0d required 1 1 01 640",
                     q_stop, stop, hit_kind, crash_x);
        end
        release_stop();
        checks++;
        if ({q_idle, stop, hit_kind, crash_x} !== {1'b1, 1'b0, 2'b01, 10'd640}) begin
            errors++;
            $display("FAIL ack_release: idle=%b stop=%b kind=%b crash=%0d required 1 0 01 640",
                     q_idle, stop, hit_kind, crash_x);
        end
        // Ack and ticks in Idle do nothing.
        ack = 1'b1; tick(); ack = 1'b0;
        checks++;
        if (q_idle !== 1'b1 || stop !== 1'b0) begin
            errors++; $display("FAIL idle_ignore: idle=%b stop=%b required 1 0", q_idle, stop);
        end
    endtask

    task automatic test_exit_and_reset();
        set_scene(10'd290, 10'd370, 10'd100);
        arm();
        tick();
        // Async reset mid-cycle with hit_cnt=1.
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({q_idle, q_armed, q_stop, stop, hit_kind, crash_x} !== {3'b100, 1'b0, 2'b00, 10'd0}) begin
            errors++;
            $display("FAIL async_reset: state=%b stop=%b kind=%b crash=%0d required 100 0 00 0",
                     {q_idle, q_armed, q_stop}, stop, hit_kind, crash_x);
        end
        step();
        reset = 1'b1;
        step();
        // Reset cleared hit_cnt: one hit after re-arm must not stop.
        tick();
        checks++;
        if (stop !== 1'b0 || q_armed !== 1'b1) begin
            errors++; $display("FAIL cnt_after_reset: stop=%b armed=%b required 0 1", stop, q_armed);
        end
        // Confirming tick coincident with Q_Count drop: exit wins.
        q_count = 1'b0;
        tick();
        checks++;
        if ({q_idle, stop, hit_kind} !== {1'b1, 1'b0, 2'b00}) begin
            errors++;
            $display("FAIL exit_wins: idle=%b stop=%b kind=%b required 1 0 00", q_idle, stop, hit_kind);
        end
    endtask

    initial begin
        test_reset();
        test_pipe_confirm();
        test_hit_restart();
        test_floor_ceil();
        test_wrap();
        test_stop_hold();
        test_exit_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
